usb_reg_bridge: RTL and testbench

Parametrised successor to the existing USB-to-register front end: bridges the SAM3U external-bus interface (ALEn/RDn/WRn/CEn) onto the internal register bus. Adds an explicit transaction FSM, async active-low reset, configurable synchroniser depth, address width and output-enable hold, a registered read pipeline with a one-cycle read strobe, and protocol-error detection. Sits between the top-level USB pins and the register decode blocks.

---
 rtl/usb_reg_pkg.sv | 18 +
 rtl/usb_reg_sync.sv | 35 +++
 rtl/usb_reg_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_usb_reg_bridge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_reg_pkg.sv
// Shared definitions for the USB external-bus to register-bus bridge:
// transaction FSM state encoding and the synchroniser depth floor.
package usb_reg_pkg;

  // Transaction FSM states with fixed encodings.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_BURST = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Fewer than two flops does not give a metastability margin.
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/usb_reg_sync.sv
// N-stage flop chain with a configurable reset value. It serves two purposes.
// On the asynchronous control strobes it is a synchroniser. On the address and
// data buses it is a delay line that keeps them aligned with the synchronised
// strobes.
module usb_reg_sync #(
  parameter int              WIDTH     = 1,
  parameter int              STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] q_reg;
    if (gi == 0) begin : g_first
      // First stage samples the raw input.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_reg <= RESET_VAL;
        else          q_reg <= d;
      end
    end else begin : g_next
      // Later stages shift the previous stage along.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_reg <= RESET_VAL;
        else          q_reg <= g_stage[gi-1].q_reg;
      end
    end
  end

  assign q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/usb_reg_bridge.sv
// Bridge from the SAM3U external bus (ALEn/RDn/WRn/CEn) to the internal
// register bus. All strobes are synchronised. The address and write-data
// buses are delayed by the same depth. A transaction FSM issues one-cycle
// reg_read and reg_write strobes and tracks the byte index within a burst.
// Optional build macro: USB_REG_ERRCNT_EN adds the saturating err_count output.
module usb_reg_bridge
  import usb_reg_pkg::*;
#(
  parameter int pADDR_WIDTH   = 8,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pSYNC_STAGES  = 2,
  parameter int pOE_HOLD      = 1
) (
  input  logic                     cwusb_clk,
  input  logic                     reset_n,
  input  logic [7:0]               cwusb_din,
  output logic [7:0]               cwusb_dout,
  output logic                     cwusb_isout,
  input  logic [pADDR_WIDTH-1:0]   cwusb_addr,
  input  logic                     cwusb_rdn,
  input  logic                     cwusb_wrn,
  input  logic                     cwusb_alen,
  input  logic                     cwusb_cen,
  output logic [pADDR_WIDTH-1:0]   reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               reg_datao,
  input  logic [7:0]               reg_datai,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid
`ifdef USB_REG_ERRCNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam int SYNC_N = (pSYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : pSYNC_STAGES;
  localparam int OE_W   = (pOE_HOLD > 1) ? $clog2(pOE_HOLD) : 1;

  // The strobes are ordered {cen, alen, wrn, rdn}. They reset to 1, which is inactive.
  logic [3:0]             ctrl_raw;
  logic [3:0]             ctrl_sync;
  logic [pADDR_WIDTH-1:0] addr_dly;
  logic [7:0]             din_dly;

  assign ctrl_raw = {cwusb_cen, cwusb_alen, cwusb_wrn, cwusb_rdn};

  for (genvar gi = 0; gi < 4; gi++) begin : g_ctrl_sync
    usb_reg_sync #(.WIDTH(1), .STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync (
      .clk(cwusb_clk), .reset_n(reset_n), .d(ctrl_raw[gi]), .q(ctrl_sync[gi])
    );
  end

  usb_reg_sync #(.WIDTH(pADDR_WIDTH), .STAGES(SYNC_N), .RESET_VAL('0)) u_addr_dly (
    .clk(cwusb_clk), .reset_n(reset_n), .d(cwusb_addr), .q(addr_dly)
  );

  usb_reg_sync #(.WIDTH(8), .STAGES(SYNC_N), .RESET_VAL('0)) u_din_dly (
    .clk(cwusb_clk), .reset_n(reset_n), .d(cwusb_din), .q(din_dly)
  );

  logic s_alen, s_rd, s_wr, s_rd_q, s_wr_q, rd_rise, wr_rise;
  assign s_alen  = ctrl_sync[2];
  assign s_rd    = ~ctrl_sync[0] & ~ctrl_sync[3];
  assign s_wr    = ~ctrl_sync[1] & ~ctrl_sync[3];
  assign rd_rise = s_rd & ~s_rd_q;
  assign wr_rise = s_wr & ~s_wr_q;

  state_t                   state_reg, state_next;
  logic [pADDR_WIDTH-1:0]   address_reg, address_next;
  logic [pBYTECNT_SIZE-1:0] bytecnt_reg, bytecnt_next;
  logic [7:0]               datao_reg, datao_next, dout_reg, dout_next;
  logic                     isout_reg, isout_next, read_reg, read_next;
  logic                     write_reg, write_next, addrvalid_reg, addrvalid_next;
  logic [OE_W-1:0]          oe_cnt_reg, oe_cnt_next;

  // State, edge-detect history and all registered outputs.
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      s_rd_q        <= 1'b0;
      s_wr_q        <= 1'b0;
      address_reg   <= '0;
      bytecnt_reg   <= '0;
      datao_reg     <= '0;
      dout_reg      <= '0;
      isout_reg     <= 1'b0;
      read_reg      <= 1'b0;
      write_reg     <= 1'b0;
      addrvalid_reg <= 1'b0;
      oe_cnt_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      s_rd_q        <= s_rd;
      s_wr_q        <= s_wr;
      address_reg   <= address_next;
      bytecnt_reg   <= bytecnt_next;
      datao_reg     <= datao_next;
      dout_reg      <= dout_next;
      isout_reg     <= isout_next;
      read_reg      <= read_next;
      write_reg     <= write_next;
      addrvalid_reg <= addrvalid_next;
      oe_cnt_reg    <= oe_cnt_next;
    end
  end

  // Next-state and output decode. ALEn low overrides everything else, and
  // simultaneous read and write strobes force the error state.
  always_comb begin
    state_next     = state_reg;
    address_next   = address_reg;
    bytecnt_next   = bytecnt_reg;
    datao_next     = datao_reg;
    dout_next      = dout_reg;
    isout_next     = isout_reg;
    read_next      = 1'b0;
    write_next     = 1'b0;
    addrvalid_next = addrvalid_reg;
    oe_cnt_next    = oe_cnt_reg;

    // Read data is captured in the cycle that follows the read strobe.
    if (read_reg) dout_next = reg_datai;
    // A write advances the byte index in the cycle after its strobe.
    if (write_reg) bytecnt_next = bytecnt_reg + pBYTECNT_SIZE'(1);
    // Once a read has ended, the output enable is kept for the hold count.
    if (isout_reg && state_reg != ST_READ) begin
      if (oe_cnt_reg != '0) oe_cnt_next = oe_cnt_reg - OE_W'(1);
      else                  isout_next  = 1'b0;
    end

    if (!s_alen) begin
      state_next     = ST_ADDR;
      address_next   = addr_dly;
      bytecnt_next   = '0;
      addrvalid_next = 1'b0;
      isout_next     = 1'b0;
      oe_cnt_next    = '0;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_IDLE;
        ST_ADDR: begin
          address_next = addr_dly;
          bytecnt_next = '0;
          state_next   = ST_BURST;
        end
        ST_BURST: begin
          addrvalid_next = 1'b1;
          if (s_rd && s_wr) begin
            state_next  = ST_ERR;
            isout_next  = 1'b0;
            oe_cnt_next = '0;
          end else if (rd_rise) begin
            state_next  = ST_READ;
            read_next   = 1'b1;
            isout_next  = 1'b1;
            oe_cnt_next = '0;
          end else if (wr_rise) begin
            state_next = ST_WRITE;
            datao_next = din_dly;
          end
        end
        ST_READ: begin
          if (s_rd && s_wr) begin
            state_next  = ST_ERR;
            isout_next  = 1'b0;
            oe_cnt_next = '0;
          end else if (!s_rd) begin
            state_next   = ST_BURST;
            bytecnt_next = bytecnt_reg + pBYTECNT_SIZE'(1);
            if (pOE_HOLD > 0) begin
              isout_next  = 1'b1;
              oe_cnt_next = OE_W'(pOE_HOLD - 1);
            end else begin
              isout_next  = 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (s_rd && s_wr) begin
            state_next  = ST_ERR;
            isout_next  = 1'b0;
            oe_cnt_next = '0;
          end else if (s_wr) begin
            datao_next = din_dly;
          end else begin
            state_next = ST_BURST;
            write_next = 1'b1;
          end
        end
        ST_ERR: begin
          isout_next  = 1'b0;
          oe_cnt_next = '0;
          if (!s_rd && !s_wr) state_next = ST_BURST;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

`ifdef USB_REG_ERRCNT_EN
  logic [7:0] errcnt_reg;
  logic       err_inc;
  assign err_inc = ((state_reg == ST_IDLE || state_reg == ST_ADDR) && (rd_rise || wr_rise))
                || (state_next == ST_ERR && state_reg != ST_ERR);

  // Saturating count of error entries and of strobes issued with no valid address.
  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n)                           errcnt_reg <= '0;
    else if (err_inc && errcnt_reg != 8'hFF) errcnt_reg <= errcnt_reg + 8'd1;
  end
  assign err_count = errcnt_reg;
`endif

  assign cwusb_dout    = dout_reg;
  assign cwusb_isout   = isout_reg;
  assign reg_address   = address_reg;
  assign reg_bytecnt   = bytecnt_reg;
  assign reg_datao     = datao_reg;
  assign reg_read      = read_reg;
  assign reg_write     = write_reg;
  assign reg_addrvalid = addrvalid_reg;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Scoreboard bench for usb_reg_bridge. The stimulus tasks drive bus cycles
// and push the expected register-side transactions into queues. A monitor
// pops those entries whenever the DUT raises a strobe or the address-valid
// flag, and compares the two.
module tb_usb_reg_bridge;
  localparam int AW   = 8;
  localparam int BC   = 2;
  localparam int SYNC = 2;
  localparam int OEH  = 1;

  logic          cwusb_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    cwusb_din = '0;
  logic [7:0]    cwusb_dout;
  logic          cwusb_isout;
  logic [AW-1:0] cwusb_addr = '0;
  logic          cwusb_rdn = 1'b1, cwusb_wrn = 1'b1, cwusb_alen = 1'b1, cwusb_cen = 1'b1;
  logic [AW-1:0] reg_address;
  logic [BC-1:0] reg_bytecnt;
  logic [7:0]    reg_datao;
  logic [7:0]    reg_datai = '0;
  logic          reg_read, reg_write, reg_addrvalid;
`ifdef USB_REG_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  usb_reg_bridge #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC), .pSYNC_STAGES(SYNC), .pOE_HOLD(OEH)) dut (
    .cwusb_clk(cwusb_clk), .reset_n(reset_n), .cwusb_din(cwusb_din), .cwusb_dout(cwusb_dout),
    .cwusb_isout(cwusb_isout), .cwusb_addr(cwusb_addr), .cwusb_rdn(cwusb_rdn), .cwusb_wrn(cwusb_wrn),
    .cwusb_alen(cwusb_alen), .cwusb_cen(cwusb_cen), .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao), .reg_datai(reg_datai), .reg_read(reg_read),
    .reg_write(reg_write), .reg_addrvalid(reg_addrvalid)
`ifdef USB_REG_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 cwusb_clk = ~cwusb_clk;

  typedef struct {
    logic [7:0] addr;
    int         bc;
    logic [7:0] data;
  } xact_t;

  xact_t      exp_wr[$];
  xact_t      exp_rd[$];
  logic [7:0] exp_addr_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_addr = '0;
  int         model_bc = 0;
  int         model_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge cwusb_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_address"}, reg_address, 0);
    chk({tag, "_bytecnt"}, reg_bytecnt, 0);
    chk({tag, "_datao"}, reg_datao, 0);
    chk({tag, "_dout"}, cwusb_dout, 0);
    chk({tag, "_isout"}, cwusb_isout, 0);
    chk({tag, "_read"}, reg_read, 0);
    chk({tag, "_write"}, reg_write, 0);
    chk({tag, "_addrvalid"}, reg_addrvalid, 0);
  endtask

  task automatic do_addr(input logic [7:0] a);
    exp_addr_q.push_back(a);
    cwusb_addr = a;
    cwusb_alen = 1'b0;
    cyc(4);
    cwusb_alen = 1'b1;
    cyc(8);
    model_addr = a;
    model_bc   = 0;
  endtask

  task automatic do_write(input logic [7:0] d, input int hold);
    xact_t e;
    e.addr = model_addr; e.bc = model_bc; e.data = d;
    exp_wr.push_back(e);
    model_bc = (model_bc + 1) % (1 << BC);
    cwusb_addr = 8'($urandom);
    cwusb_din  = d;
    cwusb_wrn  = 1'b0; cwusb_cen = 1'b0;
    cyc(hold);
    cwusb_wrn  = 1'b1; cwusb_cen = 1'b1;
    cyc(8);
    cwusb_din  = 8'($urandom);
  endtask

  task automatic do_read(input logic [7:0] d, input int hold);
    xact_t e;
    e.addr = model_addr; e.bc = model_bc; e.data = d;
    exp_rd.push_back(e);
    model_bc = (model_bc + 1) % (1 << BC);
    cwusb_addr = 8'($urandom);
    reg_datai  = d;
    cwusb_rdn  = 1'b0; cwusb_cen = 1'b0;
    cyc(hold);
    cwusb_rdn  = 1'b1; cwusb_cen = 1'b1;
    cyc(8);
  endtask

  task automatic do_err(input int hold);
    cwusb_rdn = 1'b0; cwusb_wrn = 1'b0; cwusb_cen = 1'b0;
    for (int i = 0; i < hold + 2; i++) begin
      @(negedge cwusb_clk);
      chk("isout_err", cwusb_isout, 0);
    end
    @(posedge cwusb_clk); #1;
    cwusb_rdn = 1'b1; cwusb_wrn = 1'b1; cwusb_cen = 1'b1;
    model_err++;
    cyc(8);
    $display("ERR  both strobes low for %0d cycles", hold + 2);
  endtask

  // Monitor: every strobe cycle and every rise of address-valid consumes one expected entry.
  initial begin : monitor
    logic       av_prev;
    logic       rd_pend;
    logic [7:0] rd_data;
    xact_t      e;
    logic [7:0] a;
    av_prev = 1'b0;
    rd_pend = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge cwusb_clk);
      if (rd_pend) begin
        chk("rd_dout", cwusb_dout, rd_data);
        rd_pend = 1'b0;
      end
      if (reg_write) begin
        if (exp_wr.size() == 0) chk("unexpected_write", reg_write, 0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", reg_address, e.addr);
          chk("wr_bytecnt", reg_bytecnt, e.bc);
          chk("wr_data", reg_datao, e.data);
          chk("wr_rd_excl", reg_read, 0);
          $display("WR   addr=0x%02h bc=%0d data=0x%02h", reg_address, reg_bytecnt, reg_datao);
        end
      end
      if (reg_read) begin
        if (exp_rd.size() == 0) chk("unexpected_read", reg_read, 0);
        else begin
          e = exp_rd.pop_front();
          chk("rd_addr", reg_address, e.addr);
          chk("rd_bytecnt", reg_bytecnt, e.bc);
          chk("rd_isout", cwusb_isout, 1);
          rd_pend = 1'b1;
          rd_data = e.data;
          $display("RD   addr=0x%02h bc=%0d data=0x%02h", reg_address, reg_bytecnt, e.data);
        end
      end
      if (reg_addrvalid && !av_prev) begin
        if (exp_addr_q.size() == 0) chk("unexpected_addrvalid", reg_addrvalid, 0);
        else begin
          a = exp_addr_q.pop_front();
          chk("av_addr", reg_address, a);
          chk("av_bytecnt", reg_bytecnt, 0);
          $display("ADDR addr=0x%02h", reg_address);
        end
      end
      av_prev = reg_addrvalid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned op;
    int unsigned h;
    xact_t       e;

    // Reset state.
    repeat (3) @(posedge cwusb_clk);
    #1;
    check_zero("rst");
    reset_n = 1'b1;
    cyc(4);

    // A reset that lands mid-write clears everything at once. The strobe still
    // held after release has no address behind it, so no write comes out.
    do_addr(8'h5C);
    cwusb_din = 8'h77; cwusb_wrn = 1'b0; cwusb_cen = 1'b0;
    cyc(5);
    #3 reset_n = 1'b0;
    #1 check_zero("rst_mid");
    cyc(3);
    reset_n = 1'b1;
    cyc(6);
    model_err++;
    cwusb_wrn = 1'b1; cwusb_cen = 1'b1;
    cyc(8);
    chk("av_after_rst", reg_addrvalid, 0);
    $display("RST  mid-write reset released");

    // Address 0x2A: the valid flag appears exactly SYNC+2 edges after ALEn rises.
    exp_addr_q.push_back(8'h2A);
    cwusb_addr = 8'h2A; cwusb_alen = 1'b0;
    cyc(4);
    cwusb_alen = 1'b1;
    repeat (SYNC + 1) @(posedge cwusb_clk);
    @(negedge cwusb_clk);
    chk("av_early", reg_addrvalid, 0);
    @(posedge cwusb_clk);
    @(negedge cwusb_clk);
    chk("av_on", reg_addrvalid, 1);
    chk("av_addr_2a", reg_address, 8'h2A);
    cyc(4);
    model_addr = 8'h2A; model_bc = 0;

    // ALEn dropping during a write aborts it without a strobe.
    cwusb_din = 8'hEE; cwusb_wrn = 1'b0; cwusb_cen = 1'b0;
    cyc(4);
    exp_addr_q.push_back(8'h3C);
    cwusb_addr = 8'h3C; cwusb_alen = 1'b0;
    cyc(4);
    cwusb_wrn = 1'b1; cwusb_cen = 1'b1;
    cyc(4);
    cwusb_alen = 1'b1;
    cyc(8);
    chk("abort_bytecnt", reg_bytecnt, 0);
    model_addr = 8'h3C; model_bc = 0;

    // Burst of three writes, byte index 0,1,2.
    do_write(8'h11, 3);
    do_write(8'h22, 3);
    do_write(8'h33, 3);

    // Read 0xA5, with the output-enable hold checked after RDn rises.
    e.addr = model_addr; e.bc = model_bc; e.data = 8'hA5;
    exp_rd.push_back(e);
    model_bc = (model_bc + 1) % (1 << BC);
    reg_datai = 8'hA5;
    cwusb_rdn = 1'b0; cwusb_cen = 1'b0;
    cyc(4);
    cwusb_rdn = 1'b1; cwusb_cen = 1'b1;
    repeat (SYNC + 1) @(posedge cwusb_clk);
    @(negedge cwusb_clk);
    chk("oe_hold", cwusb_isout, 1);
    chk("rd_bytecnt_inc", reg_bytecnt, model_bc);
    repeat (OEH) @(posedge cwusb_clk);
    @(negedge cwusb_clk);
    chk("oe_drop", cwusb_isout, 0);
    cyc(6);

    // Five reads on a fresh address wrap the 2-bit byte counter.
    do_addr(8'h90);
    for (int i = 0; i < 5; i++) do_read(8'($urandom), 2);
    chk("wrap_bytecnt", reg_bytecnt, model_bc);

    // Both strobes low together.
    do_err(3);

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      h  = $urandom_range(1, 4);
      if (op == 0)      do_addr(8'($urandom));
      else if (op == 1) do_err(int'(h));
      else if (op < 6)  do_write(8'($urandom), int'(h));
      else              do_read(8'($urandom), int'(h));
    end

    cyc(10);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("addr_queue_drained", exp_addr_q.size(), 0);
    chk("final_bytecnt", reg_bytecnt, model_bc);
`ifdef USB_REG_ERRCNT_EN
    chk("err_count", err_count, (model_err > 255) ? 255 : model_err);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
